// File: rtl/rv32imf_pkg.sv
// rtl/rv32imf_pkg.sv - shared types and defaults for the rv32imf instruction-bus slice
package rv32imf_pkg;

    typedef enum logic [0:0] {
        REQ_FETCH = 1'b0,
        REQ_AUX   = 1'b1
    } instr_bus_id_t;

    typedef enum logic [0:0] {
        ARB_UNLOCKED = 1'b0,
        ARB_LOCKED   = 1'b1
    } arb_lock_state_t;

    localparam int INSTR_ARB_MAX_OUTSTANDING_DEFAULT = 2;

    function automatic instr_bus_id_t other_id(input instr_bus_id_t id);
        return (id == REQ_FETCH) ? REQ_AUX : REQ_FETCH;
    endfunction

endpackage

// File: rtl/rv32imf_id_fifo.sv
// rtl/rv32imf_id_fifo.sv - in-order requester-ID FIFO for outstanding bus transactions
module rv32imf_id_fifo #(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_en;
    logic             pop_en;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_en) wr_ptr <= next_ptr(wr_ptr);
            if (pop_en)  rd_ptr <= next_ptr(rd_ptr);
            case ({push_en, pop_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_en) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rv32imf_instr_bus_arbiter.sv
// rtl/rv32imf_instr_bus_arbiter.sv - round-robin OBI arbiter for fetch and auxiliary instruction requesters
module rv32imf_instr_bus_arbiter
    import rv32imf_pkg::*;
#(
    parameter int MAX_OUTSTANDING = INSTR_ARB_MAX_OUTSTANDING_DEFAULT,
    parameter int RESET_PRIO      = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_i,
    input  logic [31:0] addr0_i,
    output logic        gnt0_o,
    output logic        rvalid0_o,
    output logic [31:0] rdata0_o,
    output logic        err0_o,
    input  logic        req1_i,
    input  logic [31:0] addr1_i,
    output logic        gnt1_o,
    output logic        rvalid1_o,
    output logic [31:0] rdata1_o,
    output logic        err1_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int ID_W  = $bits(instr_bus_id_t);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam instr_bus_id_t PRIO_INIT = (RESET_PRIO != 0) ? REQ_AUX : REQ_FETCH;

    arb_lock_state_t lock_state_q, lock_state_d;
    instr_bus_id_t   locked_id_q, locked_id_d;
    instr_bus_id_t   prio_q, prio_d;
    logic            protocol_err_q, protocol_err_d;

    instr_bus_id_t   sel;
    instr_bus_id_t   head_id;
    logic [ID_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            req_any;
    logic            locked_req_held;
    logic            lock_active;
    logic            grant;
    logic            rsp_valid;
    logic            spurious;

    assign req_any         = req0_i | req1_i;
    assign locked_req_held = (locked_id_q == REQ_FETCH) ? req0_i : req1_i;
    assign lock_active     = (lock_state_q == ARB_LOCKED) & locked_req_held;
    assign grant           = instr_req_o & instr_gnt_i;
    assign rsp_valid       = instr_rvalid_i & ~fifo_empty;
    assign spurious        = instr_rvalid_i & fifo_empty;
    assign head_id         = instr_bus_id_t'(fifo_head);

    // A lock whose owner dropped its request no longer pins the selection.
    always_comb begin
        sel = REQ_FETCH;
        if (lock_active)          sel = locked_id_q;
        else if (req0_i & req1_i) sel = prio_q;
        else if (req1_i)          sel = REQ_AUX;
    end

    rv32imf_id_fifo #(
        .WIDTH (ID_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (grant),
        .push_data (sel),
        .pop       (rsp_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_state_q   <= ARB_UNLOCKED;
            locked_id_q    <= REQ_FETCH;
            prio_q         <= PRIO_INIT;
            protocol_err_q <= 1'b0;
        end else begin
            lock_state_q   <= lock_state_d;
            locked_id_q    <= locked_id_d;
            prio_q         <= prio_d;
            protocol_err_q <= protocol_err_d;
        end
    end

    always_comb begin
        lock_state_d   = lock_state_q;
        locked_id_d    = locked_id_q;
        prio_d         = prio_q;
        protocol_err_d = protocol_err_q | spurious;
        case (lock_state_q)
            ARB_UNLOCKED: begin
                if (instr_req_o & ~instr_gnt_i) begin
                    lock_state_d = ARB_LOCKED;
                    locked_id_d  = sel;
                end
            end
            ARB_LOCKED: begin
                if (~locked_req_held & instr_req_o & ~instr_gnt_i) begin
                    locked_id_d = sel;
                end else if (instr_gnt_i | ~locked_req_held) begin
                    lock_state_d = ARB_UNLOCKED;
                end
            end
            default: lock_state_d = ARB_UNLOCKED;
        endcase
        if (grant) prio_d = other_id(sel);
    end

    always_comb begin
        instr_req_o    = req_any & ~fifo_full;
        instr_addr_o   = (sel == REQ_AUX) ? addr1_i : addr0_i;
        gnt0_o         = grant & (sel == REQ_FETCH);
        gnt1_o         = grant & (sel == REQ_AUX);
        rvalid0_o      = rsp_valid & (head_id == REQ_FETCH);
        rvalid1_o      = rsp_valid & (head_id == REQ_AUX);
        rdata0_o       = instr_rdata_i;
        rdata1_o       = instr_rdata_i;
        err0_o         = instr_err_i;
        err1_o         = instr_err_i;
        busy_o         = (fifo_count != '0) | instr_req_o;
        protocol_err_o = protocol_err_q;
    end

endmodule

// File: tb/tb_rv32imf_instr_bus_arbiter.sv
// tb/tb_rv32imf_instr_bus_arbiter.sv - scoreboard bench for the instruction-bus arbiter
module tb_rv32imf_instr_bus_arbiter;

    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_i = 1'b0, req1_i = 1'b0;
    logic [31:0] addr0_i = '0, addr1_i = '0;
    logic        gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, err0_o, err1_o;
    logic [31:0] rdata0_o, rdata1_o, instr_addr_o;
    logic        instr_req_o, busy_o, protocol_err_o;
    logic        instr_gnt_i = 1'b0, instr_rvalid_i = 1'b0, instr_err_i = 1'b0;
    logic [31:0] instr_rdata_i = '0;

    rv32imf_instr_bus_arbiter #(.MAX_OUTSTANDING(MAXO), .RESET_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0_i), .addr0_i(addr0_i), .gnt0_o(gnt0_o), .rvalid0_o(rvalid0_o),
        .rdata0_o(rdata0_o), .err0_o(err0_o),
        .req1_i(req1_i), .addr1_i(addr1_i), .gnt1_o(gnt1_o), .rvalid1_o(rvalid1_o),
        .rdata1_o(rdata1_o), .err1_o(err1_o),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
        .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
        .busy_o(busy_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          port;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t sbq[$];
    bit   mq[$];
    bit   m_prio, m_locked, m_lid, m_perr;
    bit   m_g0, m_g1;
    logic last_g0, last_g1;
    int   total = 0, passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        mq.delete();
        sbq.delete();
        m_prio = 1'b0;
        m_locked = 1'b0;
        m_lid = 1'b0;
        m_perr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req0_i = 0; req1_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; instr_err_i = 0;
        @(posedge clk);
        model_reset();
        #1 rst_n = 1'b1;
    endtask

    // One bus cycle: drive, compare against the reference arbitration rules, then advance the model.
    task automatic step(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                        input logic g, input logic rv, input logic [31:0] rd, input logic er);
        bit   e_req, e_sel, e_busy;
        rsp_t e;
        @(negedge clk);
        req0_i = r0; addr0_i = a0; req1_i = r1; addr1_i = a1;
        instr_gnt_i = g; instr_rvalid_i = rv; instr_rdata_i = rd; instr_err_i = er;
        #1;
        last_g0 = gnt0_o;
        last_g1 = gnt1_o;
        e_req = (r0 || r1) && (mq.size() < MAXO);
        if (m_locked)      e_sel = m_lid;
        else if (r0 && r1) e_sel = m_prio;
        else               e_sel = r1;
        m_g0 = e_req && g && !e_sel;
        m_g1 = e_req && g && e_sel;
        e_busy = (mq.size() != 0) || e_req;
        chk("instr_req", instr_req_o, e_req);
        if (e_req) chk("instr_addr", instr_addr_o, e_sel ? a1 : a0);
        chk("gnt0", gnt0_o, m_g0);
        chk("gnt1", gnt1_o, m_g1);
        chk("busy", busy_o, e_busy);
        chk("protocol_err", protocol_err_o, m_perr);
        if (rv) begin
            if (mq.size() > 0) begin
                e.port = mq.pop_front();
                e.data = rd;
                e.err = er;
                sbq.push_back(e);
            end else begin
                m_perr = 1'b1;
            end
        end
        if (m_g0 || m_g1) begin
            mq.push_back(e_sel);
            m_prio = !e_sel;
        end
        if (m_locked) begin
            if (g) m_locked = 1'b0;
        end else if (e_req && !g) begin
            m_locked = 1'b1;
            m_lid = e_sel;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && mq.size() > 0; k++)
            step(0, 0, 0, 0, 0, 1, $urandom, 1'($urandom % 2));
    endtask

    // Response monitor: routing is zero-latency, so expectations are due in the same cycle.
    always begin
        rsp_t e;
        @(negedge clk);
        #3;
        if (rvalid0_o || rvalid1_o) begin
            chk("rvalid_onehot", {31'b0, rvalid0_o & rvalid1_o}, 0);
            if (sbq.size() == 0) begin
                chk("unexpected_rvalid", {30'b0, rvalid1_o, rvalid0_o}, 0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_port", {31'b0, rvalid1_o}, {31'b0, e.port});
                chk("rsp_data", rvalid1_o ? rdata1_o : rdata0_o, e.data);
                chk("rsp_err", {31'b0, rvalid1_o ? err1_o : err0_o}, {31'b0, e.err});
            end
        end else if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("missing_rvalid", {31'b0, e.port}, {31'b0, ~e.port});
        end
    end

    initial begin
        logic [3:0]  order;
        logic [3:0]  fair_exp;
        logic [31:0] pa0, pa1;
        bit          pend0, pend1;
        logic        r0, r1;

        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_rvalid", {30'b0, rvalid1_o, rvalid0_o}, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Single fetch requester, response one cycle later.
        step(1, 32'h100, 0, 0, 1, 0, 0, 0);
        chk("single_gnt0", last_g0, 1);
        step(0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 0);
        chk("single_rdata0", rdata0_o, 32'hDEADBEEF);
        chk("single_rvalid1", rvalid1_o, 0);

        // Fairness from reset priority.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1, 32'h200, 1, 32'h300, 1, i > 0, 32'hA000 + i, 0);
            order[i] = last_g1;
            chk("fair_granted", last_g0 | last_g1, 1);
        end
        fair_exp = 4'b1010;
        chk("fair_order", order, fair_exp);
        drain();

        // Lock on aux while grant is withheld.
        step(0, 0, 1, 32'h400, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(1, 32'h500, 1, 32'h400, 0, 0, 0, 0);
            chk("lock_addr", instr_addr_o, 32'h400);
        end
        step(1, 32'h500, 1, 32'h400, 1, 0, 0, 0);
        chk("lock_gnt1", last_g1, 1);
        step(1, 32'h500, 1, 32'h404, 1, 0, 0, 0);
        chk("prio_after_lock", last_g0, 1);

        // FIFO full: a pop in the same cycle does not free a slot.
        step(0, 0, 1, 32'h404, 1, 0, 0, 0);
        chk("full_req", instr_req_o, 0);
        step(0, 0, 1, 32'h404, 1, 1, 32'h1234_5678, 0);
        chk("full_pop_req", instr_req_o, 0);
        step(0, 0, 1, 32'h404, 1, 0, 0, 0);
        chk("after_pop_req", instr_req_o, 1);
        drain();

        // Back-to-back push+pop across pointer wrap.
        for (int i = 0; i < 10; i++)
            step(i % 2 == 0, $urandom, i % 2 == 1, $urandom, 1, i > 0, $urandom, 1'($urandom % 2));
        drain();

        // Randomised traffic; requesters hold until granted.
        pend0 = 0; pend1 = 0; pa0 = 0; pa1 = 0;
        for (int i = 0; i < 400; i++) begin
            r0 = pend0 ? 1'b1 : 1'($urandom % 2);
            r1 = pend1 ? 1'b1 : 1'($urandom % 2);
            if (!pend0) pa0 = $urandom;
            if (!pend1) pa1 = $urandom;
            step(r0, pa0, r1, pa1, ($urandom % 4) != 0, (mq.size() > 0) && ($urandom % 2 == 1),
                 $urandom, ($urandom % 8) == 0);
            pend0 = r0 && !m_g0;
            pend1 = r1 && !m_g1;
        end
        for (int k = 0; k < 20 && (pend0 || pend1); k++) begin
            step(pend0, pa0, pend1, pa1, 1, mq.size() > 0, $urandom, 0);
            pend0 = pend0 && !m_g0;
            pend1 = pend1 && !m_g1;
        end
        drain();

        // Spurious response and reset recovery.
        step(0, 0, 0, 0, 0, 1, 32'hBAD0BAD0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("perr_sticky", protocol_err_o, 1);
        chk("perr_no_rvalid", {30'b0, rvalid1_o, rvalid0_o}, 0);
        step(1, 32'h600, 0, 0, 1, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset_perr", protocol_err_o, 0);
        chk("reset_busy", busy_o, 0);
        step(0, 0, 0, 0, 0, 1, 32'h0F0F0F0F, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("inflight_spurious", protocol_err_o, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rv32imf_instr_bus_arbiter.md
Name: rv32imf_instr_bus_arbiter

Overview:
- Shares one OBI instruction-memory port between two requesters: port 0 is the IF-stage prefetch buffer, port 1 is an auxiliary requester (debug-module program-buffer or system-bus fetch).
- Arbitrates requests with round-robin priority and locks the selection until the grant arrives, as OBI requires.
- Tracks outstanding transactions in order and routes each rvalid/rdata/err response back to its originating requester.
- Sits between the core's fetch ports and the external instruction interface.

Parameters:
- MAX_OUTSTANDING, 2, depth of the in-order requester-ID FIFO (1..8); also the cap on accepted-but-unanswered transactions.
- RESET_PRIO, 0, requester that holds round-robin priority after reset (0 or 1).

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- req0_i  in  1  fetch request
- addr0_i  in  32  fetch address
- gnt0_o  out  1  fetch grant
- rvalid0_o  out  1  fetch response valid
- rdata0_o  out  32  fetch response data
- err0_o  out  1  fetch bus error (qualified by rvalid0_o)
- req1_i  in  1  auxiliary request
- addr1_i  in  32  auxiliary address
- gnt1_o  out  1  auxiliary grant
- rvalid1_o  out  1  auxiliary response valid
- rdata1_o  out  32  auxiliary response data
- err1_o  out  1  auxiliary bus error
- instr_req_o  out  1  downstream request
- instr_addr_o  out  32  downstream address
- instr_gnt_i  in  1  downstream grant
- instr_rvalid_i  in  1  downstream response valid
- instr_rdata_i  in  32  downstream response data
- instr_err_i  in  1  downstream error
- busy_o  out  1  one or more transactions outstanding, or a request pending
- protocol_err_o  out  1  sticky flag: rvalid received with the FIFO empty

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-low: all state updates on posedge clk when rst_n==0.
- Reset values:
  - ID FIFO is empty, count=0, wr_ptr=rd_ptr=0.
  - lock=0, prio=RESET_PRIO, protocol_err_o=0.
  - All outputs derived from this state are therefore 0 (gnt*, rvalid*, instr_req_o, busy_o).
- Full condition: full = (count == MAX_OUTSTANDING).
- instr_req_o = (req0_i | req1_i) & ~full. It must not depend combinationally on instr_rvalid_i. A same-cycle pop does not free a slot for a push.
- Selection (sel), when lock=0:
  - Only one requester asserting: sel is that requester.
  - Both asserting: sel = prio.
- Selection when lock=1: sel = locked_id.
- Downstream address: instr_addr_o = addr of sel. Selected requesters must hold req and address stable until granted.
- Lock state machine (states UNLOCKED and LOCKED):
  - UNLOCKED -> LOCKED when instr_req_o=1 and instr_gnt_i=0. Store locked_id=sel.
  - LOCKED -> UNLOCKED on instr_gnt_i=1.
  - If the locked requester drops its req while locked (protocol violation), instr_req_o is still driven from the other requester's req only if lock clears. Lock clears when the locked req drops.
- Grant routing: gnt_sel_o = instr_req_o & instr_gnt_i. The other requester's grant is 0.
- Round-robin update: on every grant, prio <= ~sel. Fairness: with both requesting continuously and gnt always 1, grants alternate 0,1,0,1...
- Push: on a grant, push sel into the ID FIFO at wr_ptr. wr_ptr wraps modulo MAX_OUTSTANDING.
- Pop: on instr_rvalid_i with count>0, pop at rd_ptr.
  - rvalid<head>_o=1; rdata/err of that port = instr_rdata_i / instr_err_i.
  - The other port's rvalid is 0. Data outputs are don't-care when rvalid is 0 but are driven from instr_rdata_i (no mux latency).
- Response latency: 0 cycles, purely combinational routing.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Spurious response: rvalid with count==0 sets protocol_err_o. The response is dropped and no rvalid*_o is asserted. Only reset clears the flag.
- busy_o = (count != 0) | instr_req_o.
- Reset mid-transaction: all state is cleared; responses still in flight afterwards count as spurious (see above).

Decomposition:
- Package rv32imf_pkg gains:
  - typedef instr_bus_id_t (1 bit, enum REQ_FETCH=0, REQ_AUX=1)
  - localparam INSTR_ARB_MAX_OUTSTANDING_DEFAULT=2
- One sub-module: rv32imf_id_fifo, a parameterised in-order ID FIFO (push, pop, head, count, full, empty). The arbiter instantiates it with the width of instr_bus_id_t.

Test Plan:
- Only req0_i, addr 0x100, gnt=1 every cycle, rvalid one cycle later with data 0xDEADBEEF -> gnt0_o=1 and next-cycle rvalid0_o=1, rdata0_o=0xDEADBEEF; rvalid1_o stays 0.
- Both requesting, gnt=1 continuous, RESET_PRIO=0 -> grant order 0,1,0,1; instr_addr_o alternates addr0_i/addr1_i; responses return to the matching ports in order.
- Both requesting, gnt held low 3 cycles with sel=1 -> instr_addr_o stays addr1_i for all 3 cycles even after req0_i rises; gnt1_o pulses on cycle 4; prio becomes 0.
- MAX_OUTSTANDING=2, two grants with no rvalid -> instr_req_o=0 while full; rvalid in cycle N -> instr_req_o=1 only from cycle N+1; count returns to 1.
- Push and pop in the same cycle at count=1 -> count stays 1; pointers wrap correctly across 10 back-to-back transactions.
- rvalid with count=0 -> protocol_err_o=1 (sticky) and no rvalid*_o asserted; rst_n low for one clock -> flag cleared, count=0, busy_o=0.
